bcd_conv_arbiter: RTL and testbench

//  Shares one bin2bcd double-dabble engine among NREQ requesters, e.g. HEX

---
 rtl/bcd_arb_pkg.sv | 47 ++++
 rtl/bin2bcd.sv | 82 ++++++++
 rtl/bcd_conv_arbiter.sv | 146 ++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package : bcd_arb_pkg
//  Shared types and helpers for the round-robin BCD conversion arbiter.
//  Revision: 1.0
// ============================================================================
package bcd_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } arb_st_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Walks candidates from the highest offset down so the nearest one to ptr wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                         input logic [MAX_ID_W-1:0] ptr,
                                         input int                  nreq);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                cand = (int'(ptr) + k) % nreq;
                if (valid[cand[MAX_ID_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_ID_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module  : bin2bcd
//  Sequential double-dabble converter, one shift per clock, done after WIDTH.
//  Revision: 1.0
// ============================================================================
module bin2bcd #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_done,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    bin_q,  bin_d;
    logic [4*DIGITS-1:0] bcd_q,  bcd_d;
    logic [CNT_W-1:0]    cnt_q,  cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (i_start) begin
            bin_d  = i_bin;
            bcd_d  = '0;
            cnt_d  = CNT_W'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {w_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
            bin_d = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            // The last shift lands on the same edge that raises done.
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign o_bcd  = bcd_q;
    assign o_done = done_q;
    assign o_busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_conv_arbiter
//  Round-robin sharing of one bin2bcd engine among NREQ requesters.
//  Revision: 1.0
// ============================================================================
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int WIDTH  = 32,
    parameter  int DIGITS = 10,
    localparam int ID_W   = id_w(NREQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*WIDTH-1:0]   i_req_bin,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [NREQ-1:0]         o_rsp_valid,
    output logic [4*DIGITS-1:0]     o_rsp_bcd,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic                    o_busy,
    output logic [15:0]             o_conv_cnt
);

    arb_st_t             state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [4*DIGITS-1:0] rsp_bcd_q, rsp_bcd_d;
    logic [15:0]         conv_cnt_q, conv_cnt_d;

    logic [MAX_REQ-1:0]  w_valid8;
    logic [MAX_ID_W-1:0] w_ptr3;
    rr_pick_t            w_pick;
    logic [ID_W-1:0]     w_win;
    logic                w_accept;
    logic                w_start;
    logic [WIDTH-1:0]    w_bin;
    logic [4*DIGITS-1:0] w_eng_bcd;
    logic                w_eng_done;
    logic                w_eng_busy_unused;

    always_comb begin
        w_valid8             = '0;
        w_valid8[NREQ-1:0]   = i_req_valid;
    end

    assign w_ptr3   = MAX_ID_W'(ptr_q);
    assign w_pick   = rr_pick(w_valid8, w_ptr3, NREQ);
    assign w_win    = ID_W'(w_pick.idx);
    assign w_accept = (state_q == IDLE) && w_pick.found;
    // Operand goes straight from the winner's lane into the engine on the accept edge.
    assign w_bin    = i_req_bin[w_win*WIDTH +: WIDTH];

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_eng (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_start (w_start),
        .i_bin   (w_bin),
        .o_bcd   (w_eng_bcd),
        .o_done  (w_eng_done),
        .o_busy  (w_eng_busy_unused)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept)   state_d = CONV;
            CONV:    if (w_eng_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        w_start     = 1'b0;
        if (w_accept) begin
            o_req_ready[w_win] = 1'b1;
            w_start            = 1'b1;
        end
    end

    assign o_busy = (state_q != IDLE);

    always_comb begin
        ptr_d       = ptr_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = '0;
        rsp_bcd_d   = rsp_bcd_q;
        conv_cnt_d  = conv_cnt_q;
        if (w_accept) begin
            id_d  = w_win;
            // Wrap at NREQ, not at 2**ID_W, so unused ids are never visited.
            ptr_d = (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + ID_W'(1);
        end
        if ((state_q == CONV) && w_eng_done) begin
            rsp_bcd_d         = w_eng_bcd;
            rsp_id_d          = id_q;
            rsp_valid_d[id_q] = 1'b1;
            if (conv_cnt_q != 16'hFFFF) begin
                conv_cnt_d = conv_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q       <= '0;
            id_q        <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_bcd_q   <= '0;
            conv_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bcd_q   <= rsp_bcd_d;
            conv_cnt_q  <= conv_cnt_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_bcd   = rsp_bcd_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_conv_cnt  = conv_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bcd_conv_arbiter
//  Directed self-checking bench for the round-robin BCD conversion arbiter.
//  Revision: 1.0
// ============================================================================
module tb_bcd_conv_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;
    localparam int ID_W   = 2;
    localparam int LAT    = WIDTH + 1;
    localparam int GAP    = WIDTH + 3;

    logic                  i_clk;
    logic                  i_rstn;
    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ*WIDTH-1:0] i_req_bin;
    logic [NREQ-1:0]       o_req_ready;
    logic [NREQ-1:0]       o_rsp_valid;
    logic [4*DIGITS-1:0]   o_rsp_bcd;
    logic [ID_W-1:0]       o_rsp_id;
    logic                  o_busy;
    logic [15:0]           o_conv_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic saw_rsp    = 1'b0;
    logic saw_grant1 = 1'b0;

    bcd_conv_arbiter #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_req_valid (i_req_valid),
        .i_req_bin   (i_req_bin),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_bcd   (o_rsp_bcd),
        .o_rsp_id    (o_rsp_id),
        .o_busy      (o_busy),
        .o_conv_cnt  (o_conv_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc = cyc + 1;
        if (o_rsp_valid != '0) saw_rsp = 1'b1;
        if (o_req_ready[1])    saw_grant1 = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_bin(input int r, input logic [WIDTH-1:0] v);
        i_req_bin[r*WIDTH +: WIDTH] = v;
    endtask

    task automatic do_reset();
        i_rstn      = 1'b0;
        i_req_valid = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((o_rsp_valid == '0) && (n < 200));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while ((o_req_ready == '0) && (n < 200)) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int prev_acc;
        int acc;
        logic [NREQ-1:0]     exp_rdy [4];
        logic [4*DIGITS-1:0] exp_bcd [4];
        logic [NREQ-1:0]     rr_exp  [4];

        i_rstn      = 1'b0;
        i_req_valid = '0;
        i_req_bin   = '0;
        do_reset();

        // Reset state and idle behaviour
        chk("rst_ready",  64'(o_req_ready), 64'h0);
        chk("rst_rspv",   64'(o_rsp_valid), 64'h0);
        chk("rst_bcd",    64'(o_rsp_bcd),   64'h0);
        chk("rst_id",     64'(o_rsp_id),    64'h0);
        chk("rst_busy",   64'(o_busy),      64'h0);
        chk("rst_cnt",    64'(o_conv_cnt),  64'h0);
        saw_rsp = 1'b0;
        repeat (10) step();
        chk("idle_ready", 64'(o_req_ready), 64'h0);
        chk("idle_busy",  64'(o_busy),      64'h0);
        chk("idle_norsp", 64'(saw_rsp),     64'h0);

        // Single requester 2
        set_bin(2, 32'd12345678);
        i_req_valid = 4'b0100;
        #1;
        chk("s2_ready", 64'(o_req_ready), 64'h4);
        step();
        chk("s2_ready_conv", 64'(o_req_ready), 64'h0);
        chk("s2_busy",       64'(o_busy),      64'h1);
        i_req_valid = '0;
        set_bin(2, 32'hDEADBEEF);
        wait_rsp(n);
        chk("s2_lat",   64'(n),           64'(LAT));
        chk("s2_rspv",  64'(o_rsp_valid), 64'h4);
        chk("s2_bcd",   64'(o_rsp_bcd),   64'h0012345678);
        chk("s2_id",    64'(o_rsp_id),    64'h2);
        chk("s2_cnt",   64'(o_conv_cnt),  64'h1);
        chk("s2_busy_resp", 64'(o_busy),  64'h1);
        step();
        chk("s2_rspv_clr", 64'(o_rsp_valid), 64'h0);
        chk("s2_bcd_hold", 64'(o_rsp_bcd),   64'h0012345678);
        chk("s2_busy_idle", 64'(o_busy),     64'h0);

        // All four requesters, served in order 0..3
        do_reset();
        set_bin(0, 32'd0);
        set_bin(1, 32'd9);
        set_bin(2, 32'd1000);
        set_bin(3, 32'hFFFFFFFF);
        exp_rdy[0] = 4'b0001; exp_bcd[0] = 40'h0;
        exp_rdy[1] = 4'b0010; exp_bcd[1] = 40'h9;
        exp_rdy[2] = 4'b0100; exp_bcd[2] = 40'h1000;
        exp_rdy[3] = 4'b1000; exp_bcd[3] = 40'h4294967295;
        i_req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("s3_ready", 64'(o_req_ready), 64'(exp_rdy[k]));
            step();
            wait_rsp(n);
            chk("s3_lat", 64'(n),           64'(LAT));
            chk("s3_id",  64'(o_rsp_id),    64'(k));
            chk("s3_bcd", 64'(o_rsp_bcd),   64'(exp_bcd[k]));
            i_req_valid[k] = 1'b0;
            step();
        end
        chk("s3_cnt", 64'(o_conv_cnt), 64'h4);

        // Fairness: req0 held, req3 held
        do_reset();
        set_bin(0, 32'd1);
        set_bin(3, 32'd3);
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b1000;
        rr_exp[2] = 4'b0001;
        rr_exp[3] = 4'b1000;
        i_req_valid = 4'b1001;
        #1;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(n);
            chk("s4_grant", 64'(o_req_ready), 64'(rr_exp[k]));
            step();
            acc = cyc;
            if (k > 0) chk("s4_gap", 64'(acc - prev_acc), 64'(GAP));
            prev_acc = acc;
        end
        i_req_valid = '0;
        wait_rsp(n);
        step();

        // Reset in the middle of a conversion
        do_reset();
        set_bin(1, 32'd77);
        i_req_valid = 4'b0010;
        #1;
        chk("s5_ready", 64'(o_req_ready), 64'h2);
        step();
        i_req_valid = '0;
        repeat (WIDTH / 2) step();
        chk("s5_busy_mid", 64'(o_busy), 64'h1);
        saw_rsp = 1'b0;
        i_rstn  = 1'b0;
        #1;
        chk("s5_rst_busy", 64'(o_busy),      64'h0);
        chk("s5_rst_rspv", 64'(o_rsp_valid), 64'h0);
        step();
        i_rstn = 1'b1;
        repeat (40) step();
        chk("s5_no_rsp", 64'(saw_rsp),    64'h0);
        chk("s5_cnt0",   64'(o_conv_cnt), 64'h0);
        i_req_valid = 4'b0010;
        #1;
        chk("s5_ready2", 64'(o_req_ready), 64'h2);
        step();
        i_req_valid = '0;
        wait_rsp(n);
        chk("s5_lat", 64'(n),          64'(LAT));
        chk("s5_bcd", 64'(o_rsp_bcd),  64'h77);
        chk("s5_cnt", 64'(o_conv_cnt), 64'h1);
        step();

        // req1 withdraws during req0's conversion; then counter saturation
        do_reset();
        set_bin(0, 32'd5);
        set_bin(1, 32'd6);
        i_req_valid = 4'b0011;
        #1;
        chk("s6_ready", 64'(o_req_ready), 64'h1);
        step();
        saw_grant1 = 1'b0;
        step();
        i_req_valid = '0;
        wait_rsp(n);
        chk("s6_id",  64'(o_rsp_id),  64'h0);
        chk("s6_bcd", 64'(o_rsp_bcd), 64'h5);
        repeat (12) step();
        chk("s6_no_grant1", 64'(saw_grant1), 64'h0);

        force dut.conv_cnt_q = 16'hFFFE;
        step();
        release dut.conv_cnt_q;
        #1;
        chk("s6_preload", 64'(o_conv_cnt), 64'hFFFE);
        set_bin(2, 32'd1);
        i_req_valid = 4'b0100;
        #1;
        step();
        i_req_valid = '0;
        wait_rsp(n);
        chk("s6_cnt_max", 64'(o_conv_cnt), 64'hFFFF);
        chk("s6_bcd1",    64'(o_rsp_bcd),  64'h1);
        step();
        set_bin(2, 32'd2);
        i_req_valid = 4'b0100;
        #1;
        step();
        i_req_valid = '0;
        wait_rsp(n);
        chk("s6_cnt_sat", 64'(o_conv_cnt), 64'hFFFF);
        chk("s6_bcd2",    64'(o_rsp_bcd),  64'h2);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
